// File: rtl/bcd_disp_pkg.sv
// Shared constants and BCD decode for the result display.
// BCD_ERR_DISPLAY_EN selects how out-of-range digits are shown (see bcd_to_7seg).
package bcd_disp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StBlank = 2'd0;
  localparam state_t StHold  = 2'd1;
  localparam state_t StShow  = 2'd2;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  function automatic logic [6:0] bcd_seg(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_display_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decode with a blank override.
// With BCD_ERR_DISPLAY_EN defined, digits 10-15 show 'E'; otherwise they are blank.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      if (digit_i <= 4'd9) begin
        seg_o = bcd_seg(digit_i);
      end else begin
`ifdef BCD_ERR_DISPLAY_EN
        seg_o = SEG_E;
`else
        seg_o = SEG_BLANK;
`endif
      end
    end
  end

endmodule

// File: rtl/bcd_result_display.sv
// Captures a sign/magnitude BCD result, holds it for a minimum time and scans it onto a
// two-digit active-low seven-segment display. BCD_ERR_DISPLAY_EN enables the err output.
module bcd_result_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_sign,
  input  logic [3:0] in_digit,
  output logic       in_ready,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       err
);

  localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RefW-1:0]  RefMax   = RefW'(REFRESH_DIV - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [RefW-1:0]  ref_q, ref_d;
  logic             sel_q, sel_d;
  logic             sign_q, sign_d;
  logic [3:0]       digit_q, digit_d;
  logic             ready_q, ready_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [6:0]       dec_seg;
  logic             dec_blank;
  logic             capture;
  logic             wrap;

  assign capture = in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sign_d  = sign_q;
    digit_d = digit_q;
    if (capture) begin
      state_d = StHold;
      hold_d  = HoldLoad;
      sign_d  = in_sign;
      digit_d = in_digit;
    end else if (state_q == StHold) begin
      if (hold_q == '0) begin
        state_d = StShow;
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end
    ready_d = (state_d != StHold);
  end

  // Scan runs independently of the result FSM, including while blank.
  always_comb begin
    wrap  = (ref_q == RefMax);
    ref_d = wrap ? '0 : ref_q + 1'b1;
    sel_d = sel_q ^ wrap;
  end

  assign dec_blank = (state_q == StBlank) || sel_q;

  bcd_to_7seg u_dec (
    .digit_i (digit_q),
    .blank_i (dec_blank),
    .seg_o   (dec_seg)
  );

  always_comb begin
    an_d  = 2'b11;
    seg_d = dec_seg;
    if (state_q != StBlank) begin
      an_d = sel_q ? 2'b01 : 2'b10;
      if (sel_q && sign_q) begin
        seg_d = SEG_MINUS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBlank;
      hold_q  <= '0;
      ref_q   <= '0;
      sel_q   <= 1'b0;
      sign_q  <= 1'b0;
      digit_q <= 4'd0;
      ready_q <= 1'b1;
      an_q    <= 2'b11;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      sign_q  <= sign_d;
      digit_q <= digit_d;
      ready_q <= ready_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign in_ready = ready_q;
  assign an       = an_q;
  assign seg      = seg_q;

`ifdef BCD_ERR_DISPLAY_EN
  logic err_q, err_d;

  assign err_d = (state_q != StBlank) && (digit_q > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_result_display.sv
// Self-checking bench for bcd_result_display with REFRESH_DIV=4, HOLD_CYCLES=8.
module tb_bcd_result_display;

  localparam int unsigned RD = 4;
  localparam int unsigned HC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sign = 1'b0;
  logic [3:0] in_digit = 4'd0;
  logic       in_ready;
  logic [1:0] an;
  logic [6:0] seg;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    logic       sign;
    logic [3:0] digit;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  bcd_result_display #(
    .REFRESH_DIV (RD),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sign  (in_sign),
    .in_digit (in_digit),
    .in_ready (in_ready),
    .an       (an),
    .seg      (seg),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan counter starts from zero at the same point.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // After edge k the enables reflect the select as it stood after edge k-1.
  function automatic logic [1:0] exp_an(input int k);
    return ((((k - 1) / RD) % 2) != 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit align);
    int n = 0;
    while (!(in_ready === 1'b1 && (!align || ((cyc + 1) % RD == 0))) && n < 64) begin
      step();
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL wait_ready: in_ready=%0b not seen within 64 cycles", in_ready);
    end
  endtask

  task automatic check_disp(input string tag, input vec_t v);
    logic [1:0] ea;
    ea = exp_an(cyc);
    check({tag, "_an"}, an, ea);
    check({tag, "_seg"}, seg, (ea == 2'b10) ? v.seg0 : v.seg1);
    check({tag, "_err"}, err, v.err);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"}, an, 2'b11);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_ready"}, in_ready, 1'b1);
    check({tag, "_err"}, err, 1'b0);
  endtask

  task automatic capture_and_hold(input vec_t v);
    vec_t cur;
    wait_ready(1'b0);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_digit = v.digit;
    sb.push_back(v);
    step();
    in_valid = 1'b0;
    check("ready_fall", in_ready, 1'b0);
    cur = v;
    for (int i = 1; i <= int'(HC); i++) begin
      step();
      if (i == 1) cur = sb.pop_front();
      check("hold_ready", in_ready, (i == int'(HC)) ? 1'b1 : 1'b0);
      check_disp("hold", cur);
    end
  endtask

  initial begin
    vec_t v0, v7, v3, v5;

    vecs.push_back('{1'b1, 4'd5, 7'b0010010, 7'b0111111, 1'b0});
    vecs.push_back('{1'b0, 4'd9, 7'b0010000, 7'b1111111, 1'b0});
    vecs.push_back('{1'b1, 4'd0, 7'b1000000, 7'b0111111, 1'b0});
    vecs.push_back('{1'b0, 4'd8, 7'b0000000, 7'b1111111, 1'b0});
`ifdef BCD_ERR_DISPLAY_EN
    vecs.push_back('{1'b0, 4'd12, 7'b0000110, 7'b1111111, 1'b1});
    vecs.push_back('{1'b1, 4'd15, 7'b0000110, 7'b0111111, 1'b1});
`else
    vecs.push_back('{1'b0, 4'd12, 7'b1111111, 7'b1111111, 1'b0});
    vecs.push_back('{1'b1, 4'd15, 7'b1111111, 7'b0111111, 1'b0});
`endif

    // Reset and idle blank display
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    #29 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_reset_vals("idle");
    end

    // Table vectors: capture, hold length, scan and decode
    for (int i = 0; i < vecs.size(); i++) begin
      capture_and_hold(vecs[i]);
    end

    // in_valid held through HOLD is ignored until in_ready returns
    v0 = '{1'b0, 4'd0, 7'b1000000, 7'b1111111, 1'b0};
    v7 = '{1'b0, 4'd7, 7'b1111000, 7'b1111111, 1'b0};
    wait_ready(1'b0);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_digit = 4'd0;
    step();
    in_digit = 4'd7;
    for (int i = 1; i <= int'(HC); i++) begin
      step();
      check("t3_ready", in_ready, (i == int'(HC)) ? 1'b1 : 1'b0);
      check_disp("t3_hold", v0);
    end
    step();
    check("t3_capture", in_ready, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_disp("t3_show7", v7);
    end

    // Capture on the same edge as a refresh wrap
    v3 = '{1'b1, 4'd3, 7'b0110000, 7'b0111111, 1'b0};
    wait_ready(1'b1);
    in_valid = 1'b1;
    in_sign  = v3.sign;
    in_digit = v3.digit;
    step();
    in_valid = 1'b0;
    step();
    check_disp("t4_wrap", v3);
    step();
    check_disp("t4_next", v3);

    // Reset in the middle of HOLD
    v5 = '{1'b1, 4'd5, 7'b0010010, 7'b0111111, 1'b0};
    wait_ready(1'b0);
    in_valid = 1'b1;
    in_sign  = v5.sign;
    in_digit = v5.digit;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_disp("t6_pre", v5);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t6_async");
    #7 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_reset_vals("t6_blank");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bcd_result_display.md
# bcd_result_display

Output stage that sits directly downstream of the single-digit BCD subtractor. It captures the subtractor's sign/magnitude result through a valid/ready handshake and holds it in a result register. It drives a two-digit, time-multiplexed, active-low seven-segment display: digit 0 shows the magnitude and digit 1 shows the sign. A minimum hold time guarantees that every captured result stays visible before the next one is accepted.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit before the scan advances; must be ≥1.
- HOLD_CYCLES, 25000000: minimum number of cycles a captured result is held before `in_ready` reasserts; must be ≥1.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream result present.
- in_sign  input  1  1 = negative result.
- in_digit  input  4  BCD magnitude, nominally 0–9.
- in_ready  output  1  block can accept a result this cycle.
- an  output  2  digit enables, active-low; an[0] = magnitude, an[1] = sign.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- err  output  1  captured digit is outside the range 0–9 (only when `BCD_ERR_DISPLAY_EN` is defined).

## Operation
- Transfer: a result is captured when `in_valid && in_ready` is high at a rising edge. `in_sign` and `in_digit` are latched into the result register.
- State machine:
  - BLANK: reset state; nothing has been captured; `in_ready`=1.
  - HOLD: entered on every capture; `in_ready`=0; the hold counter is loaded with HOLD_CYCLES-1 and decrements each cycle.
  - SHOW: entered from HOLD when the counter reaches 0; `in_ready`=1. A new capture in SHOW goes back to HOLD.
- Scan:
  - A refresh counter counts from 0 to REFRESH_DIV-1 and wraps.
  - On the wrap cycle, digit select toggles (0→1→0).
  - Counter and select run in every state.
- Segment decode:
  - Standard BCD values, e.g. 0 → 7'b1000000, 5 → 7'b0010010, 8 → 7'b0000000.
  - Sign digit shows '-' (7'b0111111) when sign=1, otherwise blank (7'b1111111).
  - In BLANK, seg=7'h7F and an=2'b11.
- In HOLD and SHOW, `an` is 2'b10 when select=0 and 2'b01 when select=1.
- Digit values 10–15 are handled according to the Configuration section.

## Timing
- Reset values (asserted asynchronously while rst_n=0): an=2'b11, seg=7'h7F, in_ready=1, err=0, state BLANK, select=0, refresh and hold counters 0.
- `an`, `seg` and `err` are registered. A capture at edge N is visible on the outputs after edge N+1.
- `in_ready` is a registered state output:
  - It falls after the capture edge.
  - It stays low for exactly HOLD_CYCLES cycles.
  - It rises on the edge where the counter expires.
- HOLD_CYCLES=1: `in_ready` is low for exactly one cycle after the capture.
- A capture and a refresh wrap in the same cycle both take effect. The next cycle shows the new value on the newly selected digit.
- `in_valid` while `in_ready`=0 is ignored. Upstream must hold its data; nothing is queued.
- Reset during HOLD blanks the display immediately and discards the held result.
- REFRESH_DIV=1: the select toggles every cycle.

## Configuration
- `BCD_ERR_DISPLAY_EN` defined:
  - A captured digit in the range 10–15 displays 'E' (7'b0000110) on digit 0.
  - `err`=1 for as long as that value is held.
  - The sign digit is still decoded normally.
- `BCD_ERR_DISPLAY_EN` undefined:
  - Digits 10–15 display blank on digit 0.
  - `err` is tied to 0.

## Structure
- Shared package `bcd_disp_pkg` holds:
  - the state enum {BLANK, HOLD, SHOW};
  - the segment constants SEG_BLANK, SEG_MINUS, SEG_E;
  - the function or table for BCD-to-segment decode.
- One sub-module, `bcd_to_7seg`: combinational decode of 4-bit value plus a blank input to seg[6:0]. It is instantiated once, on the muxed digit.
- Counter widths use $clog2 of each parameter (minimum 1 bit).

## Test plan
Bench parameters for all scenarios: REFRESH_DIV=4, HOLD_CYCLES=8.
1. Reset release with no input → an=2'b11, seg=7'h7F and in_ready=1 held indefinitely.
2. Capture sign=1, digit=5 → in_ready low for 8 cycles. an alternates 2'b10 / 2'b01 every 4 cycles. seg is 7'b0010010 when an=2'b10 and 7'b0111111 when an=2'b01.
3. Capture sign=0, digit=0, then hold in_valid=1 with digit=7 during HOLD → digit 7 is not captured until in_ready returns. After that it displays 7 (7'b1111000) and the sign digit is blank.
4. Capture timed on the same edge as a refresh wrap → no glitch; the new value appears on the next cycle on the toggled digit.
5. Capture digit=12 → with the macro: seg=7'b0000110 on digit 0 and err=1. Without the macro: digit 0 blank and err=0.
6. Assert rst_n=0 mid-HOLD → all outputs return to reset values immediately. After release, the block is in BLANK with in_ready=1.
